// File: rtl/console_video_pkg.sv
// Shared types and timing constants for the console video path.
package console_video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int TILE_PX        = 8;
    localparam int BPP            = 4;
    localparam int PAL_ENTRIES    = 1 << BPP;
    localparam int RENDER_LATENCY = 6;
    localparam int BRAM_LATENCY   = 2;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous clear, used to keep side-band
// information aligned with the tile fetch pipeline.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/tile_renderer.sv
// Tilemap pixel source: raster position -> tile ID fetch -> 4bpp pattern fetch -> palette -> RGB.
// Each BRAM read data is sampled two clock edges after the edge that registers its address.
module tile_renderer
    import console_video_pkg::*;
#(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int MAP_W_LOG2 = 6,
    parameter int MAP_H_LOG2 = 5,
    parameter int TILE_ID_W  = 8,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [10:0]                      hcount_in,
    input  logic [9:0]                       vcount_in,
    input  logic                             hsync_in,
    input  logic                             vsync_in,
    input  logic                             active_in,
    input  logic                             new_frame_in,
    input  logic [15:0]                      scroll_x_in,
    input  logic [15:0]                      scroll_y_in,
    input  logic                             scroll_valid_in,
    input  logic                             pal_we_in,
    input  logic [3:0]                       pal_addr_in,
    input  logic [23:0]                      pal_data_in,
    output logic [MAP_W_LOG2+MAP_H_LOG2-1:0] map_addr_out,
    input  logic [TILE_ID_W-1:0]             map_data_in,
    output logic [TILE_ID_W+2:0]             pat_addr_out,
    input  logic [TILE_PX*BPP-1:0]           pat_data_in,
    output logic [7:0]                       red_out,
    output logic [7:0]                       green_out,
    output logic [7:0]                       blue_out,
    output logic                             hsync_out,
    output logic                             vsync_out,
    output logic                             active_out
);

    localparam int FINE_W = $clog2(TILE_PX);
    localparam int SX_W   = MAP_W_LOG2 + FINE_W;
    localparam int SY_W   = MAP_H_LOG2 + FINE_W;
    localparam logic [10:0] H_LIMIT = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIMIT = 10'(V_ACTIVE);

    logic [15:0]       shadow_x, shadow_y, live_x, live_y;
    logic [15:0]       eff_x, eff_y;
    logic [SX_W-1:0]   sx;
    logic [SY_W-1:0]   sy;
    logic              draw;
    logic [FINE_W-1:0] fx_d, fy_d;
    logic [3:0]        sync_tap;
    logic [BPP-1:0]    pix_idx;
    rgb_t              palette [PAL_ENTRIES];
    rgb_t              next_rgb;
    logic              unused_scroll;

    // The frame's first pixel already sees the scroll that becomes live at that pulse.
    always_comb begin
        eff_x = live_x;
        eff_y = live_y;
        if (new_frame_in) begin
            eff_x = scroll_valid_in ? scroll_x_in : shadow_x;
            eff_y = scroll_valid_in ? scroll_y_in : shadow_y;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow_x <= '0;
            shadow_y <= '0;
            live_x   <= '0;
            live_y   <= '0;
        end else begin
            if (scroll_valid_in) begin
                shadow_x <= scroll_x_in;
                shadow_y <= scroll_y_in;
            end
            if (new_frame_in) begin
                live_x <= eff_x;
                live_y <= eff_y;
            end
        end
    end

    // Truncating to the map size in source pixels gives wrap-around scrolling.
    assign sx   = SX_W'(hcount_in >> SCALE_LOG2) + eff_x[SX_W-1:0];
    assign sy   = SY_W'(vcount_in >> SCALE_LOG2) + eff_y[SY_W-1:0];
    assign draw = active_in && (hcount_in < H_LIMIT) && (vcount_in < V_LIMIT);
    assign unused_scroll = ^{eff_x[15:SX_W], eff_y[15:SY_W]};

    pipe_delay #(.WIDTH(FINE_W), .DEPTH(2*BRAM_LATENCY)) u_fx_delay (
        .clk(clk_in), .rst_n(rst_n_in), .d(sx[FINE_W-1:0]), .q(fx_d)
    );

    pipe_delay #(.WIDTH(FINE_W), .DEPTH(BRAM_LATENCY)) u_fy_delay (
        .clk(clk_in), .rst_n(rst_n_in), .d(sy[FINE_W-1:0]), .q(fy_d)
    );

    pipe_delay #(.WIDTH(4), .DEPTH(RENDER_LATENCY-1)) u_sync_delay (
        .clk(clk_in), .rst_n(rst_n_in),
        .d({hsync_in, vsync_in, active_in, draw}), .q(sync_tap)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            map_addr_out <= '0;
            pat_addr_out <= '0;
            pix_idx      <= '0;
        end else begin
            map_addr_out <= {sy[SY_W-1:FINE_W], sx[SX_W-1:FINE_W]};
            pat_addr_out <= {map_data_in, fy_d};
            pix_idx      <= pat_data_in[{fx_d, 2'b00} +: BPP];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                palette[i] <= '0;
            end
        end else if (pal_we_in) begin
            palette[pal_addr_in] <= rgb_t'(pal_data_in);
        end
    end

    always_comb begin
        next_rgb = '0;
        if (sync_tap[0]) begin
            next_rgb = palette[pix_idx];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            active_out <= 1'b0;
        end else begin
            red_out    <= next_rgb.r;
            green_out  <= next_rgb.g;
            blue_out   <= next_rgb.b;
            hsync_out  <= sync_tap[3];
            vsync_out  <= sync_tap[2];
            active_out <= sync_tap[1];
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Self-checking bench for tile_renderer: BRAM models plus a queue-based reference
// that derives every pixel from scroll, tilemap, pattern and palette arithmetic.
module tb_tile_renderer;

    localparam int LAT = 6;

    logic        clk_in;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hsync_in, vsync_in, active_in, new_frame_in;
    logic [15:0] scroll_x_in, scroll_y_in;
    logic        scroll_valid_in;
    logic        pal_we_in;
    logic [3:0]  pal_addr_in;
    logic [23:0] pal_data_in;
    logic [10:0] map_addr_out;
    logic [7:0]  map_data_in;
    logic [10:0] pat_addr_out;
    logic [31:0] pat_data_in;
    logic [7:0]  red_out, green_out, blue_out;
    logic        hsync_out, vsync_out, active_out;

    tile_renderer dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .active_in(active_in),
        .new_frame_in(new_frame_in),
        .scroll_x_in(scroll_x_in), .scroll_y_in(scroll_y_in), .scroll_valid_in(scroll_valid_in),
        .pal_we_in(pal_we_in), .pal_addr_in(pal_addr_in), .pal_data_in(pal_data_in),
        .map_addr_out(map_addr_out), .map_data_in(map_data_in),
        .pat_addr_out(pat_addr_out), .pat_data_in(pat_data_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .active_out(active_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [7:0]  map_mem [2048];
    logic [31:0] pat_mem [2048];

    always @(posedge clk_in) begin
        map_data_in <= map_mem[map_addr_out];
        pat_data_in <= pat_mem[pat_addr_out];
    end

    typedef struct {
        bit hs; bit vs; bit act; bit draw;
        int idx; int maddr; int paddr; bit real_px;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] pal_model [16];
    logic [15:0] shadow_x_m, shadow_y_m, live_x_m, live_y_m;
    int          n_cmp;
    int          n_err;

    task automatic model_reset();
        exp_t blank;
        blank = '{default: 0};
        exp_q.delete();
        for (int i = 0; i < LAT - 1; i++) exp_q.push_back(blank);
        for (int i = 0; i < 16; i++) pal_model[i] = 24'h0;
        shadow_x_m = 0; shadow_y_m = 0; live_x_m = 0; live_y_m = 0;
    endtask

    task automatic set_pixel(input int h, input int v, input bit act);
        hcount_in       = 11'(h);
        vcount_in       = 10'(v);
        active_in       = act;
        hsync_in        = 1'b0;
        vsync_in        = 1'b0;
        new_frame_in    = 1'b0;
        scroll_valid_in = 1'b0;
        pal_we_in       = 1'b0;
    endtask

    // One clock: predict the sampled input, advance, check addresses and the pixel leaving the pipe.
    task automatic tick();
        exp_t        e, o;
        logic [15:0] ex, ey;
        int          sx, sy, tile;
        logic [23:0] want, got;
        ex = new_frame_in ? (scroll_valid_in ? scroll_x_in : shadow_x_m) : live_x_m;
        ey = new_frame_in ? (scroll_valid_in ? scroll_y_in : shadow_y_m) : live_y_m;
        sx = (int'(hcount_in) / 2 + int'(ex)) % 512;
        sy = (int'(vcount_in) / 2 + int'(ey)) % 256;
        e.maddr = (sy / 8) * 64 + sx / 8;
        tile    = int'(map_mem[e.maddr]);
        e.paddr = tile * 8 + sy % 8;
        e.idx   = int'((pat_mem[e.paddr] >> (4 * (sx % 8))) & 32'hF);
        e.hs = hsync_in; e.vs = vsync_in; e.act = active_in;
        e.draw = active_in && (hcount_in < 11'd1280) && (vcount_in < 10'd720);
        e.real_px = 1'b1;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (map_addr_out !== 11'(e.maddr)) begin
            n_err++;
            $display("FAIL map_addr: got %0d want %0d", map_addr_out, e.maddr);
        end
        if (exp_q[exp_q.size()-3].real_px) begin
            n_cmp++;
            if (pat_addr_out !== 11'(exp_q[exp_q.size()-3].paddr)) begin
                n_err++;
                $display("FAIL pat_addr: got %0d want %0d", pat_addr_out, exp_q[exp_q.size()-3].paddr);
            end
        end
        if (exp_q.size() > LAT - 1) begin
            o = exp_q.pop_front();
            want = o.draw ? pal_model[o.idx] : 24'h0;
            got  = {red_out, green_out, blue_out};
            n_cmp++;
            if (got !== want || hsync_out !== o.hs || vsync_out !== o.vs || active_out !== o.act) begin
                n_err++;
                $display("FAIL pixel_out: got rgb=%06h hs=%b vs=%b act=%b want rgb=%06h hs=%b vs=%b act=%b",
                         got, hsync_out, vsync_out, active_out, want, o.hs, o.vs, o.act);
            end
        end
        if (pal_we_in) pal_model[pal_addr_in] = pal_data_in;
        if (scroll_valid_in) begin
            shadow_x_m = scroll_x_in;
            shadow_y_m = scroll_y_in;
        end
        if (new_frame_in) begin
            live_x_m = ex;
            live_y_m = ey;
        end
    endtask

    task automatic check_addr(input string name, input logic [10:0] want);
        n_cmp++;
        if (map_addr_out !== want) begin
            n_err++;
            $display("FAIL %s: got map_addr %0d want %0d", name, map_addr_out, want);
        end
    endtask

    task automatic check_rgb(input string name, input logic [23:0] want);
        n_cmp++;
        if ({red_out, green_out, blue_out} !== want) begin
            n_err++;
            $display("FAIL %s: got rgb %06h want %06h", name, {red_out, green_out, blue_out}, want);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({red_out, green_out, blue_out, hsync_out, vsync_out, active_out, map_addr_out, pat_addr_out} !== '0) begin
            n_err++;
            $display("FAIL %s: got rgb=%06h sync=%b%b%b map=%0d pat=%0d want all 0", name,
                     {red_out, green_out, blue_out}, hsync_out, vsync_out, active_out,
                     map_addr_out, pat_addr_out);
        end
    endtask

    task automatic test_reset();
        check_all_zero("reset_state");
    endtask

    task automatic test_palette_ramp();
        for (int k = 0; k < 16; k++) begin
            set_pixel(0, 0, 1'b0);
            pal_we_in = 1'b1; pal_addr_in = 4'(k); pal_data_in = 24'(k * 32'h111111);
            tick();
        end
        for (int i = 0; i < 22; i++) begin
            if (i < 16) set_pixel(i, 0, 1'b1);
            else        set_pixel(1300, 0, 1'b0);
            tick();
            if (i >= 5 && i < 21) check_rgb("ramp_pixel", 24'(((i - 5) / 2) * 32'h111111));
        end
    endtask

    task automatic test_sync_random();
        for (int i = 0; i < 200; i++) begin
            set_pixel(int'($urandom_range(0, 1400)), int'($urandom_range(0, 800)), 1'($urandom_range(0, 1)));
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
            new_frame_in = ($urandom_range(0, 15) == 0);
            scroll_valid_in = ($urandom_range(0, 7) == 0);
            scroll_x_in = 16'($urandom);
            scroll_y_in = 16'($urandom);
            pal_we_in = ($urandom_range(0, 3) == 0);
            pal_addr_in = 4'($urandom);
            pal_data_in = 24'($urandom);
            tick();
            if (!active_out) check_rgb("blank_black", 24'h0);
        end
    endtask

    task automatic test_scroll_coherence();
        set_pixel(0, 0, 1'b1);
        scroll_x_in = 16'd0; scroll_y_in = 16'd0; scroll_valid_in = 1'b1; new_frame_in = 1'b1;
        tick();
        check_addr("scroll_zero_frame", 11'd0);
        set_pixel(100, 4, 1'b1);
        scroll_x_in = 16'd8; scroll_valid_in = 1'b1;
        tick();
        check_addr("scroll_midframe_hold", 11'd6);
        for (int i = 1; i <= 6; i++) begin
            set_pixel(100 + 2 * i, 4, 1'b1);
            tick();
        end
        set_pixel(0, 0, 1'b1);
        new_frame_in = 1'b1;
        tick();
        check_addr("scroll_next_frame", 11'd1);
        for (int i = 1; i <= 4; i++) begin
            set_pixel(i, 0, 1'b1);
            tick();
        end
        set_pixel(0, 0, 1'b1);
        scroll_x_in = 16'd16; scroll_valid_in = 1'b1; new_frame_in = 1'b1;
        tick();
        check_addr("scroll_same_cycle", 11'd2);
    endtask

    task automatic test_wrap();
        set_pixel(0, 0, 1'b0);
        scroll_x_in = 16'h01F8; scroll_y_in = 16'd0; scroll_valid_in = 1'b1;
        tick();
        set_pixel(32, 0, 1'b1);
        new_frame_in = 1'b1;
        tick();
        check_addr("wrap_col", 11'd1);
        for (int i = 1; i <= 8; i++) begin
            set_pixel(32 + i, 0, 1'b1);
            tick();
        end
    endtask

    task automatic test_palette_midframe();
        set_pixel(1300, 0, 1'b0);
        scroll_x_in = 16'd0; scroll_y_in = 16'd0; scroll_valid_in = 1'b1; new_frame_in = 1'b1;
        pal_we_in = 1'b1; pal_addr_in = 4'd3; pal_data_in = 24'h333333;
        tick();
        for (int i = 0; i < 22; i++) begin
            if (i < 16) set_pixel(i, 0, 1'b1);
            else        set_pixel(1300, 0, 1'b0);
            if (i == 11) begin
                pal_we_in = 1'b1; pal_addr_in = 4'd3; pal_data_in = 24'hABCDEF;
            end
            tick();
            if (i == 11) check_rgb("pal_old_at_write", 24'h333333);
            if (i == 12) check_rgb("pal_new_after_write", 24'hABCDEF);
        end
    endtask

    task automatic test_reset_midline();
        set_pixel(1300, 0, 1'b0);
        scroll_x_in = 16'd64; scroll_y_in = 16'd0; scroll_valid_in = 1'b1; new_frame_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            set_pixel(4 + i, 0, 1'b1);
            hsync_in = 1'b1;
            tick();
        end
        rst_n_in = 1'b0;
        #1;
        check_all_zero("reset_midline_drop");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        model_reset();
        for (int k = 0; k < 16; k++) begin
            set_pixel(0, 0, 1'b0);
            pal_we_in = 1'b1; pal_addr_in = 4'(k); pal_data_in = 24'($urandom);
            tick();
        end
        set_pixel(200, 0, 1'b1);
        tick();
        check_addr("reset_scroll_cleared", 11'd12);
        for (int i = 1; i < 20; i++) begin
            set_pixel(200 + i, 2 * (i / 4), 1'b1);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 120; i++) begin
            set_pixel(int'($urandom_range(0, 1279)), int'($urandom_range(0, 719)), 1'b1);
            new_frame_in = ($urandom_range(0, 19) == 0);
            scroll_valid_in = ($urandom_range(0, 9) == 0);
            scroll_x_in = 16'($urandom);
            scroll_y_in = 16'($urandom);
            pal_we_in = ($urandom_range(0, 5) == 0);
            pal_addr_in = 4'($urandom);
            pal_data_in = 24'($urandom);
            tick();
        end
        for (int i = 0; i < LAT; i++) begin
            set_pixel(1300, 0, 1'b0);
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n_in = 1'b0;
        set_pixel(0, 0, 1'b0);
        scroll_x_in = 16'd0; scroll_y_in = 16'd0;
        pal_addr_in = 4'd0; pal_data_in = 24'd0;
        for (int i = 0; i < 2048; i++) begin
            map_mem[i] = 8'($urandom);
            pat_mem[i] = $urandom;
        end
        map_mem[0] = 8'd1;
        map_mem[1] = 8'd2;
        map_mem[2] = 8'd3;
        pat_mem[8] = 32'h76543210;
        repeat (3) @(posedge clk_in);
        #1;
        test_reset();
        rst_n_in = 1'b1;
        model_reset();
        test_palette_ramp();
        test_sync_random();
        test_scroll_coherence();
        test_wrap();
        test_palette_midframe();
        test_reset_midline();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
